// File: rtl/soc_completion_monitor.sv
// Run-completion monitor: snoops RAM write ports for a nonzero flag-word write, captures the
// result word, counts RUN cycles and flags a watchdog timeout. Option: SOC_MON_PORT_STATS_EN.
module soc_completion_monitor #(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned FLAG_ADDR      = 0,
  parameter int unsigned RESULT_ADDR    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned SETTLE_CYCLES  = 1,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned PortW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic [NUM_PORTS-1:0]          wr_en_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   wr_addr_i,
  input  logic [NUM_PORTS*32-1:0]       wr_data_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          timeout_o,
  output logic [31:0]                   flag_o,
  output logic [31:0]                   result_o,
  output logic [CNT_W-1:0]              cycles_o
`ifdef SOC_MON_PORT_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0]       port_wr_cnt_o,
  output logic [PortW-1:0]              flag_port_o
`endif
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {StIdle, StRun, StSettle, StDone, StTimeout} state_e;

  state_e               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cycles, w_cnt_inc;
  logic [31:0]          r_flag, r_result;
  logic [SettleW-1:0]   r_settle;

  logic                 w_flag_hit, w_result_hit;
  logic [31:0]          w_flag_data, w_result_data;
  logic                 w_run_entry, w_snoop, w_flag_complete, w_timeout_hit, w_settle_last;

  // Scan from the top port down so the lowest-index matching port wins.
  always_comb begin
    w_flag_hit    = 1'b0;
    w_flag_data   = '0;
    w_result_hit  = 1'b0;
    w_result_data = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (wr_en_i[p] && (wr_addr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(FLAG_ADDR))) begin
        w_flag_hit  = 1'b1;
        w_flag_data = wr_data_i[p*32 +: 32];
      end
      if (wr_en_i[p] && (wr_addr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(RESULT_ADDR))) begin
        w_result_hit  = 1'b1;
        w_result_data = wr_data_i[p*32 +: 32];
      end
    end
  end

  always_comb begin
    w_run_entry     = (r_state == StIdle) && start_i;
    w_snoop         = (r_state == StRun) || (r_state == StSettle);
    w_flag_complete = (r_state == StRun) && w_flag_hit && (w_flag_data != 32'd0);
    w_cnt_inc       = (r_cycles == {CNT_W{1'b1}}) ? r_cycles : r_cycles + CNT_W'(1);
    w_timeout_hit   = 32'(w_cnt_inc) >= 32'(TIMEOUT_CYCLES);
    w_settle_last   = (32'(r_settle) + 32'd1) >= 32'(SETTLE_CYCLES);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (start_i) w_state_next = StRun;
      StRun: begin
        if (w_flag_complete) w_state_next = (SETTLE_CYCLES == 0) ? StDone : StSettle;
        else if (w_timeout_hit) w_state_next = StTimeout;
      end
      StSettle:  if (w_settle_last) w_state_next = StDone;
      StDone,
      StTimeout: if (clear_i) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy_o    = (r_state == StRun) || (r_state == StSettle);
    done_o    = (r_state == StDone);
    timeout_o = (r_state == StTimeout);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycles <= '0;
      r_flag   <= '0;
      r_result <= '0;
      r_settle <= '0;
    end else if (w_run_entry) begin
      r_cycles <= '0;
      r_flag   <= '0;
      r_result <= '0;
      r_settle <= '0;
    end else if (w_snoop) begin
      if (r_state == StRun) r_cycles <= w_cnt_inc;
      if (r_state == StSettle) r_settle <= r_settle + SettleW'(1);
      if (w_flag_hit)   r_flag   <= w_flag_data;
      if (w_result_hit) r_result <= w_result_data;
    end
  end

  assign flag_o   = r_flag;
  assign result_o = r_result;
  assign cycles_o = r_cycles;

`ifdef SOC_MON_PORT_STATS_EN
  logic [NUM_PORTS*16-1:0] r_port_cnt;
  logic [PortW-1:0]        r_flag_port, w_flag_port;

  always_comb begin
    w_flag_port = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (wr_en_i[p] && (wr_addr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(FLAG_ADDR))) begin
        w_flag_port = PortW'(p);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_port_cnt  <= '0;
      r_flag_port <= '0;
    end else begin
      if (w_run_entry) begin
        r_port_cnt <= '0;
      end else if (w_snoop) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (wr_en_i[p] && (r_port_cnt[p*16 +: 16] != 16'hFFFF)) begin
            r_port_cnt[p*16 +: 16] <= r_port_cnt[p*16 +: 16] + 16'd1;
          end
        end
      end
      if (w_flag_complete) r_flag_port <= w_flag_port;
    end
  end

  assign port_wr_cnt_o = r_port_cnt;
  assign flag_port_o   = r_flag_port;
`endif

endmodule
